sdram_responder: RTL and testbench
==================================

Name: sdram_responder

Overview:
- Synthesizable behavioural model of the 16-bit SDRAM device (MT48LC16M16-class). It is the responder end of the SDRAM command bus that the chipset memory controller drives.
- Decodes cs/ras/cas/we and tracks the mode register and per-bank open rows.
- Serves CAS-latency-delayed read bursts and masked writes from a reduced on-chip array.
- Flags protocol violations. Used in simulation and FPGA self-test benches in place of the real chip.

Parameters:
- ROW_BITS, 4, stored row-address bits per bank; higher row bits alias.
- COL_BITS, 8, stored column bits; A[COL_BITS-1:0] is the column.
- T_RCD, 2, minimum clocks from ACTIVE to READ/WRITE on the same bank.

Ports:
- clk_96  in  1  device clock; all sampling on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sd_cs  in  1  chip select, active low.
- sd_ras  in  1  row address strobe, active low.
- sd_cas  in  1  column address strobe, active low.
- sd_we  in  1  write enable, active low.
- sd_ba  in  2  bank address.
- sd_addr  in  13  multiplexed address; A10 selects auto-precharge / precharge-all.
- sd_dqm  in  2  byte masks, 1 = masked; [1] = upper byte.
- sd_dq_in  in  16  data from the controller.
- sd_dq_out  out  16  read data.
- sd_dq_oe  out  1  read data valid / drive enable.
- mode_valid  out  1  a LOAD_MODE has been accepted.
- refresh_cnt  out  16  count of AUTO_REFRESH commands, wraps at 0xFFFF->0.
- err  out  1  sticky protocol-violation flag.
- err_code  out  3  code of the first violation.

Behaviour:
- Reset (async, reset_n=0):
  - sd_dq_out=0, sd_dq_oe=0, mode_valid=0, refresh_cnt=0, err=0, err_code=0.
  - All banks idle; burst and pipeline cleared.
  - Array contents are not reset.
  - Reset asserted mid-burst drops sd_dq_oe immediately.
- Command decode: cmd={cs,ras,cas,we} sampled each edge.
  - cs=1 is INHIBIT; 0111 is NOP.
  - Encodings are shared with the controller via the package.
- LOAD_MODE:
  - Legal only with all banks idle.
  - Captures BL = A[2:0] (000/001/010/011 = 1/2/4/8), type = A3, CL = A[6:4], single-write = A9.
  - Unsupported fields raise ERR_MODE and the mode is not applied: A3=1, CL not 2 or 3, or BL code >3.
- ACTIVE:
  - Target bank must be idle, else ERR_ACT.
  - Opens row A[ROW_BITS-1:0] and starts that bank's tRCD counter.
- READ/WRITE preconditions:
  - Need mode_valid, else ERR_NOMODE.
  - Bank must be active, else ERR_IDLE.
  - At least T_RCD clocks since ACTIVE, else ERR_RCD.
  - On any violation the access is ignored.
- Burst addressing: column order is sequential, wrapping inside the BL-aligned block. For beat i, col = {base[hi:log2BL], (base[log2BL-1:0]+i) mod BL}.
- READ at edge k:
  - Beat i is presented after edge k+CL-1+i, so the controller samples it at edge k+CL+i. sd_dq_oe=1 for those cycles.
  - Read DQM latency is 2: dqm=1 at edge n forces sd_dq_oe=0 for the beat sampled at edge n+2.
- WRITE at edge k:
  - Beat 0 data and dqm are sampled at edge k.
  - If single-write=1, only one beat is written. Otherwise BL beats are written at edges k..k+BL-1.
  - A masked byte keeps its old value.
- Burst interruption:
  - A new READ/WRITE, BURST_TERMINATE, or PRECHARGE of the bursting bank truncates the current burst.
  - Already-pipelined read beats are still delivered; no further beats are issued.
- Auto-precharge (A10=1 on READ/WRITE): the bank returns to idle on the edge its last beat is issued (read) or written (write). An ACTIVE to that bank earlier raises ERR_ACT.
- PRECHARGE: A10=1 idles all banks; otherwise it idles sd_ba. Precharging an idle bank is legal.
- AUTO_REFRESH:
  - All banks must be idle, else ERR_REF.
  - refresh_cnt increments in either case.
- Errors:
  - err sets on the first violation and stays set until reset.
  - err_code holds the first violation's code; later ones do not overwrite it.
- Simultaneous events: an interrupting READ/WRITE in the same edge as a pending last beat takes priority for addressing; pipelined data is unaffected.

Decomposition:
- sdram_pkg:
  - CMD_* encodings, shared with the controller.
  - Mode-field bit positions.
  - ERR_* codes: NONE=0, MODE=1, ACT=2, NOMODE=3, IDLE=4, RCD=5, REF=6.
  - Bank state typedef (idle/active + row + tRCD count).
- Sub-module sdram_responder_mem:
  - Single-port array of 4*2^ROW_BITS*2^COL_BITS x16.
  - Two byte write enables; synchronous read with 1-clock latency.
  - The responder adds a (CL-2)-stage delay pipeline after it.

Test Plan:
- Init: PRECHARGE A10=1, then LOAD_MODE A=0x222 (BL4, CL2, single-write) -> mode_valid=1, err=0.
- ACTIVE ba=1 row 5; two clocks later WRITE col 0x12 A10=1 dq=0xBEEF dqm=00; ACTIVE again; READ col 0x10 at edge k -> sd_dq_oe=1 at samples k+2..k+5 for cols 0x10,0x11,0x12,0x13, with 0xBEEF on the third beat.
- READ col 0x13 (BL4) -> beats in col order 0x13,0x10,0x11,0x12; after the last beat with A10=1 the bank is idle, so a following ACTIVE gives no error.
- WRITE 0x1234 dqm=10 over 0xBEEF -> read back 0xBE34. Read with dqm=01 at edge k+1 -> beat sampled at k+3 has sd_dq_oe=0.
- READ one clock after ACTIVE -> err=1, err_code=5; a later ACTIVE to the active bank leaves err_code=5.
- Three AUTO_REFRESH with banks idle -> refresh_cnt=3. Assert reset_n=0 mid-read-burst -> sd_dq_oe=0 immediately; after release mode_valid=0 and refresh_cnt=0.

Source files
------------

// File: rtl/sdram_pkg.sv
// sdram_pkg: definitions shared between the SDRAM responder and the memory
// controller. Holds the command encodings ({cs,ras,cas,we}), the positions of
// the mode-register fields on the address bus, the protocol-violation codes,
// the per-bank state record, and the burst column helper.
package sdram_pkg;

    // Command encodings, {cs, ras, cas, we}; any code with cs=1 is INHIBIT.
    localparam logic [3:0] CMD_LOAD_MODE    = 4'b0000;
    localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
    localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
    localparam logic [3:0] CMD_ACTIVE       = 4'b0011;
    localparam logic [3:0] CMD_WRITE        = 4'b0100;
    localparam logic [3:0] CMD_READ         = 4'b0101;
    localparam logic [3:0] CMD_BURST_TERM   = 4'b0110;
    localparam logic [3:0] CMD_NOP          = 4'b0111;

    // Mode-register field positions on the address bus.
    localparam int MODE_BL_MSB   = 2;
    localparam int MODE_BL_LSB   = 0;
    localparam int MODE_TYPE_BIT = 3;
    localparam int MODE_CL_MSB   = 6;
    localparam int MODE_CL_LSB   = 4;
    localparam int MODE_WB_BIT   = 9;
    localparam int ADDR_AP_BIT   = 10;

    // Protocol-violation codes.
    typedef enum logic [2:0] {
        ERR_NONE   = 3'd0,
        ERR_MODE   = 3'd1,
        ERR_ACT    = 3'd2,
        ERR_NOMODE = 3'd3,
        ERR_IDLE   = 3'd4,
        ERR_RCD    = 3'd5,
        ERR_REF    = 3'd6
    } err_code_t;

    // Per-bank state: open flag, full row address as received, and the
    // number of clocks still to wait before a column access is legal.
    typedef struct packed {
        logic        active;
        logic [12:0] row;
        logic [3:0]  rcd_cnt;
    } bank_state_t;

    // Column of a burst beat: sequential order, wrapping inside the
    // BL-aligned block (BL = 2**bl_code).
    function automatic logic [12:0] burst_col(input logic [12:0] base,
                                              input logic [2:0]  beat,
                                              input logic [1:0]  bl_code);
        logic [12:0] mask;
        mask = (13'd1 << bl_code) - 13'd1;
        return (base & ~mask) | ((base + {10'd0, beat}) & mask);
    endfunction

endpackage

// File: rtl/sdram_responder_mem.sv
// sdram_responder_mem: reduced single-port storage array for the responder.
// Ports:
//   clk_96 - clock
//   addr   - word address {bank, row, column}
//   be     - byte write enables, [1] = upper byte
//   wdata  - write data
//   rdata  - registered read data (one clock after addr)
// Contents are deliberately not reset so data survives a device reset.
module sdram_responder_mem
    import sdram_pkg::*;
#(
    parameter int AW = 14
) (
    input  logic          clk_96,
    input  logic [AW-1:0] addr,
    input  logic [1:0]    be,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem_r [2**AW];

    // Byte-masked write and read-before-write synchronous read.
    always_ff @(posedge clk_96) begin
        if (be[0]) begin
            mem_r[addr][7:0] <= wdata[7:0];
        end
        if (be[1]) begin
            mem_r[addr][15:8] <= wdata[15:8];
        end
        rdata <= mem_r[addr];
    end

endmodule

// File: rtl/sdram_responder.sv
// sdram_responder: behavioural 16-bit SDRAM device on the controller's bus.
// Decodes commands, tracks mode and open rows, serves CL-delayed read bursts
// and masked write bursts from a reduced array, and latches the first
// protocol violation.
// Ports:
//   clk_96, reset_n            - clock, async active-low reset
//   sd_cs/ras/cas/we           - command strobes, active low
//   sd_ba, sd_addr             - bank and multiplexed address (A10 = AP/all)
//   sd_dqm, sd_dq_in           - byte masks (1 = masked) and write data
//   sd_dq_out, sd_dq_oe        - read data and its valid/drive enable
//   mode_valid                 - a LOAD_MODE has been accepted
//   refresh_cnt                - AUTO_REFRESH count, wrapping
//   err, err_code              - sticky violation flag and first code
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 8,
    parameter int T_RCD    = 2
) (
    input  logic        clk_96,
    input  logic        reset_n,
    input  logic        sd_cs,
    input  logic        sd_ras,
    input  logic        sd_cas,
    input  logic        sd_we,
    input  logic [1:0]  sd_ba,
    input  logic [12:0] sd_addr,
    input  logic [1:0]  sd_dqm,
    input  logic [15:0] sd_dq_in,
    output logic [15:0] sd_dq_out,
    output logic        sd_dq_oe,
    output logic        mode_valid,
    output logic [15:0] refresh_cnt,
    output logic        err,
    output logic [2:0]  err_code
);

    localparam int AW = 2 + ROW_BITS + COL_BITS;
    localparam logic [3:0] RCD_INIT = 4'((T_RCD > 0) ? (T_RCD - 1) : 0);

    bank_state_t banks_r [4];
    bank_state_t cur_bank_s;
    logic [1:0]  bl_code_r;
    logic        cl3_r;
    logic        wb_single_r;

    logic        bst_active_r, bst_write_r, bst_ap_r;
    logic [1:0]  bst_bank_r;
    logic [12:0] bst_base_r;
    logic [2:0]  bst_idx_r;

    logic        rdv0_r, st_v_r;
    logic [15:0] st_data_r, mem_q_s;
    logic [1:0]  dqm_d1_r;

    logic [3:0]  cmd_s;
    logic        is_rw_s, is_write_s, is_pre_s, any_active_s, mode_ok_s;
    logic        act_ok_s, acc_ok_s, bst_stop_s, viol_s;
    err_code_t   viol_code_s;
    logic        iss_s, iss_write_s, iss_last_s, iss_ap_s;
    logic [1:0]  iss_bank_s;
    logic [2:0]  iss_idx_s, bl_last_idx_s;
    logic [12:0] iss_base_s, iss_col_full_s, iss_row_s;
    logic [AW-1:0] mem_addr_s;
    logic [1:0]  mem_be_s;
    logic        sel_v_s;
    logic [15:0] sel_d_s;
    logic        unused_s;

    assign cmd_s        = {sd_cs, sd_ras, sd_cas, sd_we};
    assign is_rw_s      = (cmd_s == CMD_READ) || (cmd_s == CMD_WRITE);
    assign is_write_s   = (cmd_s == CMD_WRITE);
    assign is_pre_s     = (cmd_s == CMD_PRECHARGE);
    assign cur_bank_s   = banks_r[sd_ba];
    assign any_active_s = banks_r[0].active | banks_r[1].active
                        | banks_r[2].active | banks_r[3].active;
    assign mode_ok_s    = !sd_addr[MODE_TYPE_BIT] && !sd_addr[MODE_BL_MSB]
                        && ((sd_addr[MODE_CL_MSB:MODE_CL_LSB] == 3'd2)
                         || (sd_addr[MODE_CL_MSB:MODE_CL_LSB] == 3'd3));
    assign act_ok_s     = (cmd_s == CMD_ACTIVE) && !cur_bank_s.active;
    // Terminate or precharge of the bursting bank cuts the burst short.
    assign bst_stop_s   = (cmd_s == CMD_BURST_TERM)
                        || (is_pre_s && (sd_addr[ADDR_AP_BIT] || (sd_ba == bst_bank_r)));
    assign bl_last_idx_s = (3'd1 << bl_code_r) - 3'd1;
    assign unused_s     = ^{sd_addr, bst_base_r, iss_col_full_s, iss_row_s};

    // Violation check of the command sampled on this edge.
    always_comb begin
        viol_s      = 1'b0;
        viol_code_s = ERR_NONE;
        acc_ok_s    = 1'b0;
        case (cmd_s)
            CMD_LOAD_MODE: begin
                if (any_active_s || !mode_ok_s) begin
                    viol_s = 1'b1; viol_code_s = ERR_MODE;
                end else begin
                    viol_s = 1'b0;
                end
            end
            CMD_ACTIVE: begin
                if (cur_bank_s.active) begin
                    viol_s = 1'b1; viol_code_s = ERR_ACT;
                end else begin
                    viol_s = 1'b0;
                end
            end
            CMD_READ, CMD_WRITE: begin
                if (!mode_valid) begin
                    viol_s = 1'b1; viol_code_s = ERR_NOMODE;
                end else if (!cur_bank_s.active) begin
                    viol_s = 1'b1; viol_code_s = ERR_IDLE;
                end else if (cur_bank_s.rcd_cnt != 4'd0) begin
                    viol_s = 1'b1; viol_code_s = ERR_RCD;
                end else begin
                    acc_ok_s = is_rw_s;
                end
            end
            CMD_AUTO_REFRESH: begin
                if (any_active_s) begin
                    viol_s = 1'b1; viol_code_s = ERR_REF;
                end else begin
                    viol_s = 1'b0;
                end
            end
            default: viol_s = 1'b0;
        endcase
    end

    // Beat issued to the array this edge: a new access wins over the burst.
    always_comb begin
        iss_s       = 1'b0;
        iss_write_s = 1'b0;
        iss_last_s  = 1'b0;
        iss_ap_s    = 1'b0;
        iss_bank_s  = bst_bank_r;
        iss_idx_s   = bst_idx_r;
        iss_base_s  = bst_base_r;
        if (acc_ok_s) begin
            iss_s       = 1'b1;
            iss_write_s = is_write_s;
            iss_bank_s  = sd_ba;
            iss_idx_s   = 3'd0;
            iss_base_s  = sd_addr;
            iss_last_s  = (bl_code_r == 2'd0) || (is_write_s && wb_single_r);
            iss_ap_s    = sd_addr[ADDR_AP_BIT];
        end else if (bst_active_r && !bst_stop_s) begin
            iss_s       = 1'b1;
            iss_write_s = bst_write_r;
            iss_last_s  = (bst_idx_r == bl_last_idx_s);
            iss_ap_s    = bst_ap_r;
        end else begin
            iss_s = 1'b0;
        end
        iss_col_full_s = burst_col(iss_base_s, iss_idx_s, bl_code_r);
        iss_row_s      = banks_r[iss_bank_s].row;
        mem_addr_s     = {iss_bank_s, iss_row_s[ROW_BITS-1:0], iss_col_full_s[COL_BITS-1:0]};
        mem_be_s       = (iss_s && iss_write_s) ? ~sd_dqm : 2'b00;
    end

    sdram_responder_mem #(.AW(AW)) u_mem (
        .clk_96 (clk_96),
        .addr   (mem_addr_s),
        .be     (mem_be_s),
        .wdata  (sd_dq_in),
        .rdata  (mem_q_s)
    );

    // Bank open/close and tRCD countdown.
    always_ff @(posedge clk_96 or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < 4; b++) begin
                banks_r[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (banks_r[b].rcd_cnt != 4'd0) begin
                    banks_r[b].rcd_cnt <= banks_r[b].rcd_cnt - 4'd1;
                end
                if (is_pre_s && (sd_addr[ADDR_AP_BIT] || (sd_ba == 2'(b)))) begin
                    banks_r[b].active <= 1'b0;
                end
                // Auto-precharge closes the bank on its final beat.
                if (iss_s && iss_last_s && iss_ap_s && (iss_bank_s == 2'(b))) begin
                    banks_r[b].active <= 1'b0;
                end
                if (act_ok_s && (sd_ba == 2'(b))) begin
                    banks_r[b].active  <= 1'b1;
                    banks_r[b].row     <= sd_addr;
                    banks_r[b].rcd_cnt <= RCD_INIT;
                end
            end
        end
    end

    // Mode register capture.
    always_ff @(posedge clk_96 or negedge reset_n) begin
        if (!reset_n) begin
            mode_valid  <= 1'b0;
            bl_code_r   <= 2'd0;
            cl3_r       <= 1'b0;
            wb_single_r <= 1'b0;
        end else if ((cmd_s == CMD_LOAD_MODE) && !viol_s) begin
            mode_valid  <= 1'b1;
            bl_code_r   <= sd_addr[MODE_BL_LSB+1:MODE_BL_LSB];
            cl3_r       <= (sd_addr[MODE_CL_MSB:MODE_CL_LSB] == 3'd3);
            wb_single_r <= sd_addr[MODE_WB_BIT];
        end
    end

    // Burst engine state.
    always_ff @(posedge clk_96 or negedge reset_n) begin
        if (!reset_n) begin
            bst_active_r <= 1'b0;
            bst_write_r  <= 1'b0;
            bst_ap_r     <= 1'b0;
            bst_bank_r   <= 2'd0;
            bst_base_r   <= 13'd0;
            bst_idx_r    <= 3'd0;
        end else if (acc_ok_s) begin
            bst_active_r <= !iss_last_s;
            bst_write_r  <= is_write_s;
            bst_ap_r     <= sd_addr[ADDR_AP_BIT];
            bst_bank_r   <= sd_ba;
            bst_base_r   <= sd_addr;
            bst_idx_r    <= 3'd1;
        end else if (iss_s) begin
            bst_active_r <= !iss_last_s;
            bst_idx_r    <= bst_idx_r + 3'd1;
        end else if (bst_stop_s) begin
            bst_active_r <= 1'b0;
        end
    end

    // CL=3 takes the extra stage, CL=2 uses the array output directly.
    always_comb begin
        if (cl3_r) begin
            sel_v_s = st_v_r;
            sel_d_s = st_data_r;
        end else begin
            sel_v_s = rdv0_r;
            sel_d_s = mem_q_s;
        end
    end

    // Read pipeline and output register; dqm is delayed one clock here so
    // that together with the output register it masks two clocks later.
    always_ff @(posedge clk_96 or negedge reset_n) begin
        if (!reset_n) begin
            rdv0_r    <= 1'b0;
            st_v_r    <= 1'b0;
            st_data_r <= 16'd0;
            dqm_d1_r  <= 2'b00;
            sd_dq_oe  <= 1'b0;
            sd_dq_out <= 16'd0;
        end else begin
            rdv0_r    <= iss_s && !iss_write_s;
            st_v_r    <= rdv0_r;
            st_data_r <= mem_q_s;
            dqm_d1_r  <= sd_dqm;
            sd_dq_oe  <= sel_v_s && !(|dqm_d1_r);
            if (sel_v_s) begin
                sd_dq_out <= sel_d_s;
            end
        end
    end

    // Refresh counter and sticky first-error capture.
    always_ff @(posedge clk_96 or negedge reset_n) begin
        if (!reset_n) begin
            refresh_cnt <= 16'd0;
            err         <= 1'b0;
            err_code    <= 3'd0;
        end else begin
            if (cmd_s == CMD_AUTO_REFRESH) begin
                refresh_cnt <= refresh_cnt + 16'd1;
            end
            if (viol_s && !err) begin
                err      <= 1'b1;
                err_code <= viol_code_s;
            end
        end
    end

endmodule

// File: tb/tb_sdram_responder.sv
// Directed self-checking bench for sdram_responder.
module tb_sdram_responder;
    import sdram_pkg::*;

    logic        clk_96 = 1'b0;
    logic        reset_n;
    logic        sd_cs, sd_ras, sd_cas, sd_we;
    logic [1:0]  sd_ba;
    logic [12:0] sd_addr;
    logic [1:0]  sd_dqm;
    logic [15:0] sd_dq_in;
    logic [15:0] sd_dq_out;
    logic        sd_dq_oe;
    logic        mode_valid;
    logic [15:0] refresh_cnt;
    logic        err;
    logic [2:0]  err_code;

    int checks = 0;
    int errors = 0;

    sdram_responder dut (
        .clk_96      (clk_96),
        .reset_n     (reset_n),
        .sd_cs       (sd_cs),
        .sd_ras      (sd_ras),
        .sd_cas      (sd_cas),
        .sd_we       (sd_we),
        .sd_ba       (sd_ba),
        .sd_addr     (sd_addr),
        .sd_dqm      (sd_dqm),
        .sd_dq_in    (sd_dq_in),
        .sd_dq_out   (sd_dq_out),
        .sd_dq_oe    (sd_dq_oe),
        .mode_valid  (mode_valid),
        .refresh_cnt (refresh_cnt),
        .err         (err),
        .err_code    (err_code)
    );

    always #5 clk_96 = ~clk_96;

    task automatic tick();
        @(posedge clk_96);
        #1;
    endtask

    task automatic drive_nop();
        {sd_cs, sd_ras, sd_cas, sd_we} = CMD_NOP;
        sd_ba    = 2'd0;
        sd_addr  = 13'd0;
        sd_dqm   = 2'b00;
        sd_dq_in = 16'd0;
    endtask

    task automatic issue(input logic [3:0] cmd, input logic [1:0] ba,
                         input logic [12:0] addr, input logic [15:0] dq,
                         input logic [1:0] dqm);
        {sd_cs, sd_ras, sd_cas, sd_we} = cmd;
        sd_ba    = ba;
        sd_addr  = addr;
        sd_dq_in = dq;
        sd_dqm   = dqm;
        tick();
        drive_nop();
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        drive_nop();
        sd_cs = 1'b1;
        #3;
        check("rst_oe", {15'd0, sd_dq_oe}, 16'd0);
        check("rst_dq", sd_dq_out, 16'd0);
        check("rst_mode_valid", {15'd0, mode_valid}, 16'd0);
        check("rst_refresh", refresh_cnt, 16'd0);
        check("rst_err", {15'd0, err}, 16'd0);
        check("rst_err_code", {13'd0, err_code}, 16'd0);
        #19;
        reset_n = 1'b1;
        drive_nop();
        tick();

        // Init: precharge all, BL4 / CL2 / single-write.
        issue(CMD_PRECHARGE, 2'd0, 13'h400, 16'h0, 2'b00);
        issue(CMD_LOAD_MODE, 2'd0, 13'h222, 16'h0, 2'b00);
        check("lmr_mode_valid", {15'd0, mode_valid}, 16'd1);
        check("lmr_err", {15'd0, err}, 16'd0);

        // Fill bank 1 row 5, cols 0x10..0x13; last write auto-precharges.
        issue(CMD_ACTIVE, 2'd1, 13'h005, 16'h0, 2'b00);
        tick();
        issue(CMD_WRITE, 2'd1, 13'h010, 16'h1111, 2'b00);
        issue(CMD_WRITE, 2'd1, 13'h011, 16'h2222, 2'b00);
        issue(CMD_WRITE, 2'd1, 13'h013, 16'h4444, 2'b00);
        issue(CMD_WRITE, 2'd1, 13'h412, 16'hBEEF, 2'b00);
        issue(CMD_ACTIVE, 2'd1, 13'h005, 16'h0, 2'b00);
        check("reactivate_after_ap_err", {15'd0, err}, 16'd0);
        tick();

        // READ col 0x10, CL2: beats after edges k+1..k+4.
        issue(CMD_READ, 2'd1, 13'h010, 16'h0, 2'b00);
        check("rd10_not_yet", {15'd0, sd_dq_oe}, 16'd0);
        tick(); check("rd10_b0_oe", {15'd0, sd_dq_oe}, 16'd1); check("rd10_b0", sd_dq_out, 16'h1111);
        tick(); check("rd10_b1_oe", {15'd0, sd_dq_oe}, 16'd1); check("rd10_b1", sd_dq_out, 16'h2222);
        tick(); check("rd10_b2_oe", {15'd0, sd_dq_oe}, 16'd1); check("rd10_b2", sd_dq_out, 16'hBEEF);
        tick(); check("rd10_b3_oe", {15'd0, sd_dq_oe}, 16'd1); check("rd10_b3", sd_dq_out, 16'h4444);
        tick(); check("rd10_end_oe", {15'd0, sd_dq_oe}, 16'd0);

        // READ col 0x13 with auto-precharge: wrap order 13,10,11,12.
        issue(CMD_READ, 2'd1, 13'h413, 16'h0, 2'b00);
        tick(); check("rd13_b0", sd_dq_out, 16'h4444);
        tick(); check("rd13_b1", sd_dq_out, 16'h1111);
        tick(); check("rd13_b2", sd_dq_out, 16'h2222);
        tick(); check("rd13_b3", sd_dq_out, 16'hBEEF);
        check("rd13_b3_oe", {15'd0, sd_dq_oe}, 16'd1);
        issue(CMD_ACTIVE, 2'd1, 13'h005, 16'h0, 2'b00);
        check("act_after_rd_ap_err", {15'd0, err}, 16'd0);
        check("rd13_end_oe", {15'd0, sd_dq_oe}, 16'd0);
        tick();

        // Upper byte masked write, then read with dqm at k+1.
        issue(CMD_WRITE, 2'd1, 13'h012, 16'h1234, 2'b10);
        issue(CMD_READ, 2'd1, 13'h012, 16'h0, 2'b00);
        sd_dqm = 2'b01;
        tick();
        sd_dqm = 2'b00;
        check("mask_b0_oe", {15'd0, sd_dq_oe}, 16'd1);
        check("mask_b0", sd_dq_out, 16'hBE34);
        tick(); check("dqm_b1_oe", {15'd0, sd_dq_oe}, 16'd0);
        tick(); check("dqm_b2_oe", {15'd0, sd_dq_oe}, 16'd1); check("dqm_b2", sd_dq_out, 16'h1111);
        tick(); check("dqm_b3", sd_dq_out, 16'h2222);

        // tRCD violation, then a second violation must not overwrite.
        issue(CMD_ACTIVE, 2'd2, 13'h003, 16'h0, 2'b00);
        check("act2_err", {15'd0, err}, 16'd0);
        issue(CMD_READ, 2'd2, 13'h000, 16'h0, 2'b00);
        check("rcd_err", {15'd0, err}, 16'd1);
        check("rcd_code", {13'd0, err_code}, 16'd5);
        tick(); tick();
        check("rcd_ignored_oe", {15'd0, sd_dq_oe}, 16'd0);
        issue(CMD_ACTIVE, 2'd1, 13'h005, 16'h0, 2'b00);
        check("act_err_sticky", {15'd0, err}, 16'd1);
        check("act_code_kept", {13'd0, err_code}, 16'd5);

        // Refresh with all banks idle.
        issue(CMD_PRECHARGE, 2'd0, 13'h400, 16'h0, 2'b00);
        issue(CMD_AUTO_REFRESH, 2'd0, 13'h000, 16'h0, 2'b00);
        issue(CMD_AUTO_REFRESH, 2'd0, 13'h000, 16'h0, 2'b00);
        issue(CMD_AUTO_REFRESH, 2'd0, 13'h000, 16'h0, 2'b00);
        check("refresh_cnt3", refresh_cnt, 16'd3);

        // Reset during a read burst.
        issue(CMD_ACTIVE, 2'd0, 13'h000, 16'h0, 2'b00);
        tick();
        issue(CMD_READ, 2'd0, 13'h000, 16'h0, 2'b00);
        tick();
        check("pre_reset_oe", {15'd0, sd_dq_oe}, 16'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_oe", {15'd0, sd_dq_oe}, 16'd0);
        #2;
        reset_n = 1'b1;
        tick();
        check("post_reset_mode", {15'd0, mode_valid}, 16'd0);
        check("post_reset_refresh", refresh_cnt, 16'd0);
        check("post_reset_err", {15'd0, err}, 16'd0);

        // Unsupported CL rejected, then CL3 read of preserved array data.
        issue(CMD_LOAD_MODE, 2'd0, 13'h242, 16'h0, 2'b00);
        check("bad_cl_err", {15'd0, err}, 16'd1);
        check("bad_cl_code", {13'd0, err_code}, 16'd1);
        check("bad_cl_mode", {15'd0, mode_valid}, 16'd0);
        issue(CMD_LOAD_MODE, 2'd0, 13'h232, 16'h0, 2'b00);
        check("cl3_mode", {15'd0, mode_valid}, 16'd1);
        issue(CMD_ACTIVE, 2'd1, 13'h005, 16'h0, 2'b00);
        tick();
        issue(CMD_READ, 2'd1, 13'h011, 16'h0, 2'b00);
        tick(); check("cl3_k1_oe", {15'd0, sd_dq_oe}, 16'd0);
        tick(); check("cl3_b0_oe", {15'd0, sd_dq_oe}, 16'd1); check("cl3_b0", sd_dq_out, 16'h2222);
        tick(); check("cl3_b1", sd_dq_out, 16'hBE34);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
